// File: rtl/hazard_detect_unit.sv
// Hazard detection for the 5-stage MIPS pipeline: MEM/WB match flags for the forwarding unit,
// a load-use stall FSM that holds PC and IF/ID and bubbles ID/EX, and saturating perf counters.
module hazard_detect_unit #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pipe_en,
    input  logic             flush,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwen,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwen,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwen,
    output logic             data_hazard_mem,
    output logic             data_hazard_wb,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             stalling,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    typedef enum logic [0:0] {StRun, StStall} state_e;

    // The RUN cycle that detects the load-use counts as the first held cycle.
    localparam logic [2:0] LatInit    = 3'(LOAD_LAT - 1);
    localparam bit         MultiCycle = (LOAD_LAT > 1);

    state_e           state_q;
    logic [2:0]       lat_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_q;

    logic haz_mem;
    logic haz_wb;
    logic load_use;
    logic hold;
    logic in_stall;

    always_comb begin
        haz_mem  = mem_regwen & (mem_rd != 5'd0) & ((mem_rd == ex_rs) | (mem_rd == ex_rt));
        haz_wb   = wb_regwen & (wb_rd != 5'd0) & ((wb_rd == ex_rs) | (wb_rd == ex_rt));
        load_use = ex_memread & ex_regwen & (ex_rd != 5'd0) &
                   ((ex_rd == rs_id) | (ex_rd == rt_id));
        in_stall = (state_q == StStall);
        // Flush squashes the dependent instruction, so holding it would be pointless.
        hold     = ~RST & ~flush & (in_stall | load_use);
    end

    assign data_hazard_mem = ~RST & haz_mem;
    assign data_hazard_wb  = ~RST & haz_wb;
    assign pc_hold         = hold;
    assign ifid_hold       = hold;
    assign idex_bubble     = hold;
    assign stalling        = ~RST & in_stall;
    assign stall_cnt       = stall_cnt_q;
    assign fwd_cnt         = fwd_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StRun;
            lat_q       <= 3'd0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (pipe_en) begin
            unique case (state_q)
                StRun: begin
                    if (load_use && !flush && MultiCycle) begin
                        state_q <= StStall;
                        lat_q   <= LatInit;
                    end
                end
                StStall: begin
                    if (flush || lat_q <= 3'd1) begin
                        state_q <= StRun;
                        lat_q   <= 3'd0;
                    end else begin
                        lat_q <= lat_q - 3'd1;
                    end
                end
            endcase

            if (idex_bubble && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if ((data_hazard_mem || data_hazard_wb) && fwd_cnt_q != '1) begin
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed bench for hazard_detect_unit: one instance with LOAD_LAT=1/CNT_W=16, one with
// LOAD_LAT=3/CNT_W=4, both sharing the same stimulus.
module tb_hazard_detect_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic       pipe_en, flush;
    logic [4:0] rs_id, rt_id, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       ex_regwen, ex_memread, mem_regwen, wb_regwen;

    logic        a_dhm, a_dhw, a_pc_hold, a_ifid_hold, a_idex_bubble, a_stalling;
    logic [15:0] a_stall_cnt, a_fwd_cnt;
    logic        b_dhm, b_dhw, b_pc_hold, b_ifid_hold, b_idex_bubble, b_stalling;
    logic [3:0]  b_stall_cnt, b_fwd_cnt;

    logic [3:0] a_ctl, b_ctl;
    assign a_ctl = {a_pc_hold, a_ifid_hold, a_idex_bubble, a_stalling};
    assign b_ctl = {b_pc_hold, b_ifid_hold, b_idex_bubble, b_stalling};

    int tests_run = 0;
    int failed    = 0;

    bit lat3_pen   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit lat3_stall [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 CLK = ~CLK;

    hazard_detect_unit #(.LOAD_LAT(1), .CNT_W(16)) u_lat1 (
        .CLK(CLK), .RST(RST), .pipe_en(pipe_en), .flush(flush),
        .rs_id(rs_id), .rt_id(rt_id), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwen(ex_regwen), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwen(mem_regwen), .wb_rd(wb_rd), .wb_regwen(wb_regwen),
        .data_hazard_mem(a_dhm), .data_hazard_wb(a_dhw), .pc_hold(a_pc_hold),
        .ifid_hold(a_ifid_hold), .idex_bubble(a_idex_bubble), .stalling(a_stalling),
        .stall_cnt(a_stall_cnt), .fwd_cnt(a_fwd_cnt)
    );

    hazard_detect_unit #(.LOAD_LAT(3), .CNT_W(4)) u_lat3 (
        .CLK(CLK), .RST(RST), .pipe_en(pipe_en), .flush(flush),
        .rs_id(rs_id), .rt_id(rt_id), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwen(ex_regwen), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwen(mem_regwen), .wb_rd(wb_rd), .wb_regwen(wb_regwen),
        .data_hazard_mem(b_dhm), .data_hazard_wb(b_dhw), .pc_hold(b_pc_hold),
        .ifid_hold(b_ifid_hold), .idex_bubble(b_idex_bubble), .stalling(b_stalling),
        .stall_cnt(b_stall_cnt), .fwd_cnt(b_fwd_cnt)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        pipe_en = 1'b0; flush = 1'b0;
        rs_id = 5'd0; rt_id = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
        mem_rd = 5'd0; wb_rd = 5'd0;
        ex_regwen = 1'b0; ex_memread = 1'b0; mem_regwen = 1'b0; wb_regwen = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        ex_memread = 1'b1; ex_regwen = 1'b1; ex_rd = rd;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1; pipe_en = 1'b1;
        set_load(5'd5); rs_id = 5'd5;
        mem_rd = 5'd3; mem_regwen = 1'b1; ex_rt = 5'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            tests_run++;
            if ({a_ctl, b_ctl, a_dhm, a_dhw, b_dhm, b_dhw} !== 12'd0) begin
                failed++;
                $display("FAIL reset_outputs cyc%0d: got a_ctl=%b b_ctl=%b dh=%b%b, want all 0",
                         i, a_ctl, b_ctl, a_dhm, a_dhw);
            end
            step();
        end
        clear_inputs();
        RST = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (b_ctl !== 4'b0000) begin
            failed++;
            $display("FAIL reset_state_run: got b_ctl=%b, want 0000", b_ctl);
        end
        step();
        tests_run++;
        if ({a_stall_cnt, a_fwd_cnt, b_stall_cnt, b_fwd_cnt} !== 40'd0) begin
            failed++;
            $display("FAIL reset_counters: got %0d %0d %0d %0d, want 0 0 0 0",
                     a_stall_cnt, a_fwd_cnt, b_stall_cnt, b_fwd_cnt);
        end
    endtask

    task automatic test_mem_wb_hazard();
        do_reset();
        mem_rd = 5'd3; mem_regwen = 1'b1; wb_rd = 5'd3; wb_regwen = 1'b1; ex_rt = 5'd3;
        pipe_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests_run++;
            if ({a_dhm, a_dhw} !== 2'b11) begin
                failed++;
                $display("FAIL both_hazards cyc%0d: got %b%b, want 11", i, a_dhm, a_dhw);
            end
            step();
            tests_run++;
            if (a_fwd_cnt !== 16'(i + 1)) begin
                failed++;
                $display("FAIL fwd_cnt_inc cyc%0d: got %0d, want %0d", i, a_fwd_cnt, i + 1);
            end
        end
        pipe_en = 1'b0;
        step();
        tests_run++;
        if (a_fwd_cnt !== 16'd3) begin
            failed++;
            $display("FAIL fwd_cnt_stalled_pipe: got %0d, want 3", a_fwd_cnt);
        end
        pipe_en = 1'b1; mem_rd = 5'd7; ex_rs = 5'd7; wb_rd = 5'd9;
        @(negedge CLK);
        tests_run++;
        if ({a_dhm, a_dhw} !== 2'b10) begin
            failed++;
            $display("FAIL mem_only_rs: got %b%b, want 10", a_dhm, a_dhw);
        end
        step();
        mem_rd = 5'd3; mem_regwen = 1'b0; wb_rd = 5'd3;
        @(negedge CLK);
        tests_run++;
        if ({a_dhm, a_dhw} !== 2'b01) begin
            failed++;
            $display("FAIL wb_only: got %b%b, want 01", a_dhm, a_dhw);
        end
        step();
        mem_rd = 5'd0; mem_regwen = 1'b1; wb_rd = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
        @(negedge CLK);
        tests_run++;
        if ({a_dhm, a_dhw, b_dhm, b_dhw} !== 4'b0000) begin
            failed++;
            $display("FAIL reg0_no_hazard: got %b%b, want 00", a_dhm, a_dhw);
        end
        step();
        tests_run++;
        if (a_fwd_cnt !== 16'd5 || b_fwd_cnt !== 4'd5) begin
            failed++;
            $display("FAIL fwd_cnt_final: got %0d/%0d, want 5/5", a_fwd_cnt, b_fwd_cnt);
        end
    endtask

    task automatic test_load_use_lat1();
        do_reset();
        set_load(5'd8); rt_id = 5'd8; pipe_en = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (a_ctl !== 4'b1110 || b_ctl !== 4'b1110) begin
            failed++;
            $display("FAIL lu_nopipe: got a=%b b=%b, want 1110", a_ctl, b_ctl);
        end
        step();
        tests_run++;
        if (a_stall_cnt !== 16'd0 || b_ctl !== 4'b1110) begin
            failed++;
            $display("FAIL lu_nopipe_hold: got cnt=%0d b=%b, want 0 1110", a_stall_cnt, b_ctl);
        end
        pipe_en = 1'b1;
        @(negedge CLK);
        tests_run++;
        if (a_ctl !== 4'b1110) begin
            failed++;
            $display("FAIL lu_lat1_assert: got %b, want 1110", a_ctl);
        end
        step();
        ex_memread = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (a_ctl !== 4'b0000 || a_stall_cnt !== 16'd1) begin
            failed++;
            $display("FAIL lu_lat1_release: got ctl=%b cnt=%0d, want 0000 1", a_ctl, a_stall_cnt);
        end
    endtask

    task automatic test_load_use_lat3();
        do_reset();
        set_load(5'd12); rs_id = 5'd12;
        for (int i = 0; i < 5; i++) begin
            pipe_en = lat3_pen[i];
            @(negedge CLK);
            tests_run++;
            if (b_ctl !== {3'b111, lat3_stall[i]}) begin
                failed++;
                $display("FAIL lu_lat3 cyc%0d: got %b, want %b", i, b_ctl, {3'b111, lat3_stall[i]});
            end
            step();
            if (i == 0) ex_memread = 1'b0;
        end
        @(negedge CLK);
        tests_run++;
        if (b_ctl !== 4'b0000 || b_stall_cnt !== 4'd3) begin
            failed++;
            $display("FAIL lu_lat3_done: got ctl=%b cnt=%0d, want 0000 3", b_ctl, b_stall_cnt);
        end
    endtask

    task automatic test_flush_in_stall();
        do_reset();
        set_load(5'd6); rt_id = 5'd6; pipe_en = 1'b1;
        step();
        ex_memread = 1'b0; flush = 1'b1; pipe_en = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (b_ctl !== 4'b0001) begin
            failed++;
            $display("FAIL flush_nopipe: got %b, want 0001", b_ctl);
        end
        step();
        pipe_en = 1'b1;
        @(negedge CLK);
        tests_run++;
        if (b_ctl !== 4'b0001) begin
            failed++;
            $display("FAIL flush_pipe_held: got %b, want 0001", b_ctl);
        end
        step();
        flush = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (b_ctl !== 4'b0000 || b_stall_cnt !== 4'd1) begin
            failed++;
            $display("FAIL flush_to_run: got ctl=%b cnt=%0d, want 0000 1", b_ctl, b_stall_cnt);
        end
        ex_memread = 1'b1; flush = 1'b1;
        @(negedge CLK);
        tests_run++;
        if (b_ctl !== 4'b0000) begin
            failed++;
            $display("FAIL flush_in_run: got %b, want 0000", b_ctl);
        end
        step();
        ex_memread = 1'b0; flush = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (b_ctl !== 4'b0000 || b_stall_cnt !== 4'd1) begin
            failed++;
            $display("FAIL flush_in_run_after: got ctl=%b cnt=%0d, want 0000 1", b_ctl, b_stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_load(5'd6); rs_id = 5'd6; pipe_en = 1'b1;
        mem_rd = 5'd6; mem_regwen = 1'b1; ex_rs = 5'd6;
        step();
        ex_memread = 1'b0;
        step();
        tests_run++;
        if (b_ctl !== 4'b1111 || b_stall_cnt !== 4'd2 || b_fwd_cnt !== 4'd2) begin
            failed++;
            $display("FAIL pre_reset_stall: got ctl=%b st=%0d fw=%0d, want 1111 2 2",
                     b_ctl, b_stall_cnt, b_fwd_cnt);
        end
        RST = 1'b1;
        @(negedge CLK);
        tests_run++;
        if (b_ctl !== 4'b0000 || {b_dhm, b_dhw} !== 2'b00) begin
            failed++;
            $display("FAIL reset_in_stall: got ctl=%b dh=%b%b, want 0000 00", b_ctl, b_dhm, b_dhw);
        end
        step();
        RST = 1'b0;
        clear_inputs();
        @(negedge CLK);
        tests_run++;
        if (b_ctl !== 4'b0000 || b_stall_cnt !== 4'd0 || b_fwd_cnt !== 4'd0) begin
            failed++;
            $display("FAIL reset_in_stall_after: got ctl=%b st=%0d fw=%0d, want 0000 0 0",
                     b_ctl, b_stall_cnt, b_fwd_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_rd = 5'd4; mem_regwen = 1'b1; ex_rs = 5'd4; pipe_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int exp_b;
            step();
            exp_b = (i + 1 > 15) ? 15 : i + 1;
            tests_run++;
            if (b_fwd_cnt !== 4'(exp_b) || a_fwd_cnt !== 16'(i + 1)) begin
                failed++;
                $display("FAIL fwd_saturate cyc%0d: got %0d/%0d, want %0d/%0d",
                         i, b_fwd_cnt, a_fwd_cnt, exp_b, i + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mem_wb_hazard();
        test_load_use_lat1();
        test_load_use_lat3();
        test_flush_in_stall();
        test_reset_mid_stall();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
- Sits directly upstream of the forwarding unit in the 5-stage MIPS pipeline.
- Compares EX-stage source registers against MEM/WB destinations and drives data_hazard_mem and data_hazard_wb, which the forwarding unit consumes.
- Detects load-use hazards in ID and runs a stall FSM that holds PC and IF/ID and injects bubbles into ID/EX for a parameterised load latency.
- Keeps saturating stall and forwarding-event counters for debug and performance.

Parameters:
- LOAD_LAT, 1, number of advancing cycles a load-use dependent instruction is held in ID (1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- CLK  in  1  pipeline clock.
- RST  in  1  synchronous, active-high reset.
- pipe_en  in  1  pipeline advance enable for this cycle (ihit and no dmem wait).
- flush  in  1  branch/jump taken; squashes IF/ID contents.
- rs_id  in  5  ID-stage rs.
- rt_id  in  5  ID-stage rt.
- ex_rs  in  5  EX-stage rs.
- ex_rt  in  5  EX-stage rt.
- ex_rd  in  5  EX-stage destination.
- ex_regwen  in  1  EX instruction writes the register file.
- ex_memread  in  1  EX instruction is a load.
- mem_rd  in  5  MEM-stage destination.
- mem_regwen  in  1  MEM instruction writes the register file.
- wb_rd  in  5  WB-stage destination.
- wb_regwen  in  1  WB instruction writes the register file.
- data_hazard_mem  out  1  EX source matches the MEM destination; to the forwarding unit.
- data_hazard_wb  out  1  EX source matches the WB destination; to the forwarding unit.
- pc_hold  out  1  freeze PC.
- ifid_hold  out  1  freeze the IF/ID latch.
- idex_bubble  out  1  load a NOP into ID/EX.
- stalling  out  1  FSM is in STALL.
- stall_cnt  out  CNT_W  advancing cycles with idex_bubble=1, saturating.
- fwd_cnt  out  CNT_W  advancing cycles with either data_hazard output=1, saturating.

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous, active-high.
- Reset state: while RST=1, all combinational outputs are forced to 0. On the first edge with RST=1: state=RUN, down-counter=0, stall_cnt=0, fwd_cnt=0.
- Reset mid-STALL: returns the FSM to RUN on that edge with no residual hold.

Hazard compare (combinational, zero latency):
- data_hazard_mem = mem_regwen & (mem_rd!=0) & ((mem_rd==ex_rs)|(mem_rd==ex_rt)).
- data_hazard_wb = wb_regwen & (wb_rd!=0) & ((wb_rd==ex_rs)|(wb_rd==ex_rt)).
- Both may be 1 at once. Priority between them is decided in the forwarding unit, not here.
- Register 0 never produces a hazard.

Load-use detect:
- load_use = ex_memread & ex_regwen & (ex_rd!=0) & ((ex_rd==rs_id)|(ex_rd==rt_id)).

FSM (RUN, STALL) with a 3-bit down-counter:
- RUN:
  - pc_hold, ifid_hold and idex_bubble = load_use & ~flush (Mealy, same cycle as detection).
  - If load_use & ~flush & pipe_en: if LOAD_LAT>1, go to STALL with counter=LOAD_LAT-1; else stay in RUN.
- STALL:
  - pc_hold=ifid_hold=idex_bubble=1 and stalling=1 (Moore). The load_use input is ignored.
  - When pipe_en=1, the counter decrements. When it reaches 0 on that edge, go to RUN.
  - When pipe_en=0, the state and counter hold.
- flush:
  - flush=1 in any state forces pc_hold, ifid_hold and idex_bubble to 0.
  - flush=1 & pipe_en=1 in STALL returns the FSM to RUN and clears the counter, because the dependent instruction is squashed.
  - flush=1 & pipe_en=0 holds the state.
- pipe_en=0 in RUN with load_use=1: outputs are still asserted; no state change.

Counters:
- stall_cnt increments on an edge where pipe_en & idex_bubble.
- fwd_cnt increments on an edge where pipe_en & (data_hazard_mem|data_hazard_wb).
- Both saturate at all-ones and never wrap.
- Both counters update independently in the same cycle.

Test Plan:
- Reset: RST=1 for 2 cycles while ex_memread=1 and ex_rd=rs_id=5 -> all outputs 0 during reset. Next cycle: state RUN, stall_cnt=0, fwd_cnt=0.
- MEM/WB hazards: mem_rd=3, mem_regwen=1, wb_rd=3, wb_regwen=1, ex_rt=3 -> data_hazard_mem=data_hazard_wb=1, fwd_cnt +1 per pipe_en cycle. Repeat with mem_rd=0 and wb_rd=0 -> both 0.
- Load-use, LOAD_LAT=1: ex_memread=1, ex_rd=rt_id=8, pipe_en=1 -> exactly one cycle of pc_hold=ifid_hold=idex_bubble=1, stalling stays 0, stall_cnt=1.
- Load-use, LOAD_LAT=3 with pipe_en low for 2 cycles mid-stall -> idex_bubble high for 3 advancing cycles (5 clock cycles total), stall_cnt=3, then RUN.
- Flush in STALL: LOAD_LAT=3, flush=1 with pipe_en=1 on the 2nd stall cycle -> hold/bubble drop to 0 that cycle, state RUN next edge. Separately, RST=1 mid-STALL -> RUN with counters cleared.
- Saturation: CNT_W=4, continuous hazard for 20 advancing cycles -> fwd_cnt stops at 15 and never wraps to 0.
